// File: rtl/binref_game_ctrl_pkg.sv
// Shared constants for the binary-refinement game controller: mode codes,
// LFSR seed/taps and the BCD player-name width.
package binref_pkg;

   localparam logic [2:0] MODE_SCORE     = 3'b000;
   localparam logic [2:0] MODE_LEADER    = 3'b001;
   localparam logic [2:0] MODE_GAME      = 3'b010;
   localparam logic [2:0] MODE_RESULT    = 3'b011;
   localparam logic [2:0] MODE_NEWPLAYER = 3'b100;

   typedef enum logic [2:0] {
      ST_SCORE     = MODE_SCORE,
      ST_LEADER    = MODE_LEADER,
      ST_GAME      = MODE_GAME,
      ST_RESULT    = MODE_RESULT,
      ST_NEWPLAYER = MODE_NEWPLAYER
   } mode_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shifting Galois form of taps 16,14,13,11
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int          NAME_W    = 12;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/binref_game_ctrl_if.sv
// Keypad/button/display bundle between the input conditioning, the game
// controller (slave) and whoever drives and observes it (master).
interface binref_game_ctrl_if #(
   parameter int SW_W        = 8,
   parameter int SCORE_W     = 16,
   parameter int NUM_PLAYERS = 4
);
   localparam int SLOT_W = $clog2(NUM_PLAYERS);
   localparam int NAME_W = binref_pkg::NAME_W;

   logic                tick_1hz;
   logic [SW_W-1:0]     sw;
   logic                btn_newgame;
   logic                btn_newplayer;
   logic                btn_score;
   logic                btn_submit;
   logic                key_valid;
   logic [3:0]          key_digit;

   logic [2:0]          mode;
   logic [SW_W-1:0]     chal;
   logic                chal_neg;
   logic [SW_W-1:0]     chal_mag;
   logic [5:0]          time_left;
   logic                last_correct;
   logic [SCORE_W-1:0]  last_points;
   logic [SLOT_W-1:0]   cur_slot;
   logic [NAME_W-1:0]   cur_name;
   logic [SCORE_W-1:0]  cur_score;
   logic [NAME_W-1:0]   leader_name;
   logic [SCORE_W-1:0]  leader_score;

   modport master (
      output tick_1hz, sw, btn_newgame, btn_newplayer, btn_score, btn_submit,
             key_valid, key_digit,
      input  mode, chal, chal_neg, chal_mag, time_left, last_correct, last_points,
             cur_slot, cur_name, cur_score, leader_name, leader_score
   );

   modport slave (
      input  tick_1hz, sw, btn_newgame, btn_newplayer, btn_score, btn_submit,
             key_valid, key_digit,
      output mode, chal, chal_neg, chal_mag, time_left, last_correct, last_points,
             cur_slot, cur_name, cur_score, leader_name, leader_score
   );

endinterface

// File: rtl/binref_game_ctrl_lfsr.sv
// Free-running 16-bit Galois LFSR used as the challenge source.
module binref_lfsr
   import binref_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] state_o
);

   logic [15:0] state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LFSR_SEED;
      end else begin
         state_q <= lfsr_next(state_q);
      end
   end

   assign state_o = state_q;

endmodule

// File: rtl/binref_game_ctrl.sv
// Binary-refinement game controller: mode FSM, challenge, round timer, scoring.
// Optional macro BINREF_SIGNED_CHAL_EN shows the challenge as a signed value.
module binref_game_ctrl
   import binref_pkg::*;
#(
   parameter int SW_W        = 8,
   parameter int TIME_LIMIT  = 20,
   parameter int RESULT_HOLD = 2,
   parameter int NUM_PLAYERS = 4,
   parameter int SCORE_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   binref_game_ctrl_if.slave    bus
);

   localparam int SLOT_W = $clog2(NUM_PLAYERS);
   localparam int HOLD_W = $clog2(RESULT_HOLD + 1);

   logic [15:0]          lfsr_state;

   mode_e                mode_q;
   logic [SLOT_W-1:0]    slot_q;
   logic [NAME_W-1:0]    name_tbl_q  [NUM_PLAYERS];
   logic [SCORE_W-1:0]   score_tbl_q [NUM_PLAYERS];
   logic [SW_W-1:0]      chal_q;
   logic                 chal_neg_q;
   logic [SW_W-1:0]      chal_mag_q;
   logic [5:0]           time_q;
   logic                 last_correct_q;
   logic [SCORE_W-1:0]   last_points_q;
   logic [HOLD_W-1:0]    hold_q;
   logic                 wr_vld_q;
   logic [NAME_W-1:0]    wr_name_q;
   logic [SCORE_W-1:0]   wr_score_q;
   logic [NAME_W-1:0]    leader_name_q;
   logic [SCORE_W-1:0]   leader_score_q;

   logic [SLOT_W-1:0]    slot_d;
   logic [NAME_W-1:0]    name_d;
   logic [SW_W-1:0]      chal_d;
   logic                 chal_neg_d;
   logic [SW_W-1:0]      chal_mag_d;
   logic                 correct_d;
   logic [SCORE_W-1:0]   points_d;
   logic [SCORE_W-1:0]   score_d;

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [SCORE_W-1:0] b);
      logic [SCORE_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
   endfunction

   function automatic logic [SW_W-1:0] chal_sample(input logic [SW_W-1:0] raw);
      return (raw == '0) ? SW_W'(1) : raw;
   endfunction

`ifdef BINREF_SIGNED_CHAL_EN
   // Negating the most negative value wraps back to itself, which read as
   // unsigned is exactly 2^(SW_W-1).
   function automatic logic [SW_W-1:0] chal_abs(input logic signed [SW_W-1:0] v);
      return v[SW_W-1] ? SW_W'(-v) : SW_W'(v);
   endfunction
`endif

   binref_lfsr u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .state_o (lfsr_state)
   );

   if (SW_W < 16) begin : g_lfsr_hi
      logic unused_lfsr_hi;
      assign unused_lfsr_hi = ^lfsr_state[15:SW_W];
   end

   assign slot_d    = slot_q + SLOT_W'(1);
   assign name_d    = {name_tbl_q[slot_q][NAME_W-5:0], bus.key_digit};
   assign chal_d    = chal_sample(lfsr_state[SW_W-1:0]);
   assign correct_d = (bus.sw == chal_q);
   assign points_d  = correct_d ? SCORE_W'(time_q) : '0;
   assign score_d   = sat_add(score_tbl_q[slot_q], points_d);

`ifdef BINREF_SIGNED_CHAL_EN
   assign chal_neg_d = chal_d[SW_W-1];
   assign chal_mag_d = chal_abs(chal_d);
`else
   assign chal_neg_d = 1'b0;
   assign chal_mag_d = chal_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q         <= ST_NEWPLAYER;
         slot_q         <= '0;
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            name_tbl_q[i]  <= '0;
            score_tbl_q[i] <= '0;
         end
         chal_q         <= '0;
         chal_neg_q     <= 1'b0;
         chal_mag_q     <= '0;
         time_q         <= '0;
         last_correct_q <= 1'b0;
         last_points_q  <= '0;
         hold_q         <= '0;
         wr_vld_q       <= 1'b0;
         wr_name_q      <= '0;
         wr_score_q     <= '0;
      end else begin
         wr_vld_q <= 1'b0;
         if (bus.btn_newplayer) begin
            slot_q              <= slot_d;
            name_tbl_q[slot_d]  <= '0;
            score_tbl_q[slot_d] <= '0;
            mode_q              <= ST_NEWPLAYER;
         end else begin
            case (mode_q)
               ST_NEWPLAYER: begin
                  if (bus.key_valid && (bus.key_digit <= 4'd9)) begin
                     name_tbl_q[slot_q] <= name_d;
                  end
                  if (bus.btn_submit) begin
                     mode_q <= ST_SCORE;
                  end
               end
               ST_SCORE, ST_LEADER: begin
                  if (bus.btn_newgame) begin
                     chal_q     <= chal_d;
                     chal_neg_q <= chal_neg_d;
                     chal_mag_q <= chal_mag_d;
                     time_q     <= 6'(TIME_LIMIT);
                     mode_q     <= ST_GAME;
                  end else if (bus.btn_score) begin
                     mode_q <= (mode_q == ST_SCORE) ? ST_LEADER : ST_SCORE;
                  end
               end
               ST_GAME: begin
                  // Submit takes priority over a same-cycle tick and scores the
                  // time still showing.
                  if (bus.btn_submit) begin
                     last_correct_q      <= correct_d;
                     last_points_q       <= points_d;
                     score_tbl_q[slot_q] <= score_d;
                     wr_vld_q            <= 1'b1;
                     wr_name_q           <= name_tbl_q[slot_q];
                     wr_score_q          <= score_d;
                     hold_q              <= HOLD_W'(RESULT_HOLD);
                     mode_q              <= ST_RESULT;
                  end else if (bus.tick_1hz) begin
                     time_q <= time_q - 6'd1;
                     if (time_q <= 6'd1) begin
                        last_correct_q <= 1'b0;
                        last_points_q  <= '0;
                        hold_q         <= HOLD_W'(RESULT_HOLD);
                        mode_q         <= ST_RESULT;
                     end
                  end
               end
               ST_RESULT: begin
                  if (bus.tick_1hz) begin
                     hold_q <= hold_q - HOLD_W'(1);
                     if (hold_q <= HOLD_W'(1)) begin
                        mode_q <= ST_SCORE;
                     end
                  end
               end
               default: mode_q <= ST_NEWPLAYER;
            endcase
         end
      end
   end

   // Leader compares against the captured write, so a later clear of that
   // slot cannot disturb the record.
   always_ff @(posedge clk) begin
      if (rst) begin
         leader_name_q  <= '0;
         leader_score_q <= '0;
      end else if (wr_vld_q && (wr_score_q > leader_score_q)) begin
         leader_name_q  <= wr_name_q;
         leader_score_q <= wr_score_q;
      end
   end

   assign bus.mode         = mode_q;
   assign bus.chal         = chal_q;
   assign bus.chal_neg     = chal_neg_q;
   assign bus.chal_mag     = chal_mag_q;
   assign bus.time_left    = time_q;
   assign bus.last_correct = last_correct_q;
   assign bus.last_points  = last_points_q;
   assign bus.cur_slot     = slot_q;
   assign bus.cur_name     = name_tbl_q[slot_q];
   assign bus.cur_score    = score_tbl_q[slot_q];
   assign bus.leader_name  = leader_name_q;
   assign bus.leader_score = leader_score_q;

endmodule

// File: doc/binref_game_ctrl.md
# binref_game_ctrl

Parametrised game controller for the binary-refinement game. It generalises the fixed 8-switch, single-player mode logic into a configurable challenge width, round time, result hold time and multi-slot player table with a leader record. The block sits between the debouncers/keypad and the display demux. It owns:
- the mode FSM;
- challenge generation;
- the round timer;
- scoring.

## Interface
Parameters:
- SW_W, 8: challenge/switch width, 2..16
- TIME_LIMIT, 20: round length in 1 Hz ticks, 1..63
- RESULT_HOLD, 2: ticks spent in RESULT before returning to SCORE, ≥1
- NUM_PLAYERS, 4: player slots, power of two, 2..16
- SCORE_W, 16: score width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-cycle strobe, once per second
- sw  in  SW_W  player guess
- btn_newgame, btn_newplayer, btn_score, btn_submit  in  1 each  debounced one-cycle pulses
- key_valid  in  1  keypad digit strobe
- key_digit  in  4  keypad digit
- mode  out  3  current mode code
- chal  out  SW_W  current challenge
- chal_neg  out  1  challenge sign for display
- chal_mag  out  SW_W  challenge magnitude for display
- time_left  out  6  remaining ticks in GAME
- last_correct  out  1  result of last round
- last_points  out  SCORE_W  points from last round
- cur_slot  out  log2(NUM_PLAYERS)  active player
- cur_name  out  12  three BCD digits of the active player
- cur_score  out  SCORE_W  score of the active player
- leader_name  out  12  leader name
- leader_score  out  SCORE_W  leader score

## Operation
- Mode codes:
  - SCORE = 000
  - LEADER = 001
  - GAME = 010
  - RESULT = 011
  - NEWPLAYER = 100
- Reset:
  - mode = NEWPLAYER, cur_slot = 0;
  - all names, scores and leader fields = 0;
  - chal = 0, time_left = 0;
  - last_correct = 0, last_points = 0;
  - LFSR = 16'hACE1.
- Priority in any cycle: rst > btn_newplayer > mode-specific events. btn_newplayer in any mode:
  - cur_slot increments mod NUM_PLAYERS;
  - that slot's name and score are cleared;
  - mode goes to NEWPLAYER.
- NEWPLAYER:
  - key_valid with key_digit ≤ 9 shifts the digit into cur_name from the LSB side; digits > 9 are ignored.
  - btn_submit goes to SCORE.
  - All other buttons are ignored.
- SCORE and LEADER:
  - btn_score toggles between SCORE and LEADER.
  - btn_newgame samples the LFSR low SW_W bits into chal (a sample of 0 is replaced by 1), loads time_left = TIME_LIMIT, and goes to GAME.
  - If btn_score and btn_newgame arrive together, btn_newgame wins.
- GAME:
  - btn_submit sets last_correct = (sw == chal), and sets last_points = time_left if correct, else 0.
  - On submit, the slot score adds last_points, saturating at 2^SCORE_W−1, and mode goes to RESULT.
  - tick_1hz decrements time_left. When time_left reaches 0 from a tick, the round times out: last_correct = 0, last_points = 0, mode goes to RESULT.
  - If submit and tick arrive in the same cycle, submit wins and uses the pre-decrement time_left.
- RESULT:
  - A hold counter loads RESULT_HOLD on entry and decrements on each tick; at 0 the mode goes to SCORE.
  - Buttons other than btn_newplayer are ignored.
- Leader update is evaluated on every score write:
  - if the new slot score > leader_score (strict), copy the slot name and score into the leader fields;
  - on ties the incumbent stays.
  - Clearing or overwriting a slot never changes the leader record.
- The LFSR is a 16-bit Galois LFSR with taps 16,14,13,11. It advances every clk.

## Timing
- All outputs are registered.
- mode changes on the clk edge after the qualifying pulse (1-cycle latency).
- Score and last_* update on the same edge as the GAME→RESULT transition.
- leader_* update one cycle after the score write.
- time_left updates on the edge after tick_1hz.
- Buttons are assumed to be single-cycle pulses; a level held high re-fires every cycle.
- rst mid-round aborts immediately with no score change.

## Configuration
- BINREF_SIGNED_CHAL_EN defined:
  - chal is interpreted as two's complement;
  - chal_neg = chal[SW_W−1];
  - chal_mag = |chal|, and SW_W'h…80 maps to magnitude 2^(SW_W−1).
- Undefined: chal_neg tied to 0 and chal_mag = chal.
- Matching is the raw bitwise compare in both cases.

## Structure
- Package binref_pkg holds:
  - the mode code localparams;
  - the LFSR seed and tap mask;
  - the name width constant (12).
- One sub-module, binref_lfsr (16-bit, clk/rst, output state), instantiated once.
- The player table is a NUM_PLAYERS-entry register array of names and scores.

## Test plan
- Reset, then type keys 1,2,3,11, then submit → cur_name = 12'h123, mode = SCORE, cur_score = 0.
- Newgame, 5 ticks, sw = chal, submit → last_correct = 1, last_points = 15, cur_score = 15, RESULT; after 2 ticks → SCORE.
- Newgame, 20 ticks with no submit → RESULT with last_points = 0 and score unchanged.
- Submit and tick in the same cycle with time_left = 1 → correct, last_points = 1.
- Slot0 scores 15. Newplayer to slot1, which scores 15 → leader stays slot0 (tie). Slot1 then scores 3 more → leader_score = 18, leader_name = slot1's name.
- With BINREF_SIGNED_CHAL_EN and SW_W = 8, force chal = 8'hF6 → chal_neg = 1, chal_mag = 10.
